// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: defaults, the NOP word,
// FSM state encodings, the IF/ID payload layout and the fetch-fault check.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_AW_DEFAULT    = 10;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetchState_e;

  // Everything IF/ID carries besides its valid bit.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ifIdPayload_t;

  // Misaligned, below the region base, or at/above base + 4*2^aw.
  // The top bound is formed in 33 bits so a region ending at 2^32 still works.
  function automatic logic fetchFault(input logic [31:0] pc, input logic [31:0] base,
                                      input int unsigned aw);
    logic [32:0] top;
    top = {1'b0, base} + (33'd4 << aw);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= top);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port. The fetch unit is the master: it drives the
// byte offset and the combinational memory returns the word in the same cycle.
interface fetch_unit_if;

  logic [31:0] im_addr;
  logic [31:0] im_data;

  modport master (output im_addr, input im_data);
  modport slave  (input im_addr, output im_data);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Generic pipeline stage register with valid bit, stall (hold) and bubble
// (clear) controls. Bubble overrides stall so a flush lands even while held.
module if_id_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             bubble,
  input  logic             validIn,
  input  logic [Width-1:0] dataIn,
  output logic             validOut,
  output logic [Width-1:0] dataOut
);

  // Priority: reset > bubble > stall > load.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      validOut <= 1'b0;
      dataOut  <= '0;
    end else if (!stall) begin
      validOut <= validIn;
      dataOut  <= dataIn;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory, detects
// fetch faults, runs the RUN/HALT state machine and feeds the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IM_AW      = IM_AW_DEFAULT,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  fetch_unit_if.master imem,
  output logic [31:0]  pc_out,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_pc8,
  output logic         id_fault,
  output logic [31:0]  fetch_count
);

  logic [31:0]  pcQ;
  logic [31:0]  countQ;
  fetchState_e  stateQ;

  logic         fault;
  logic         bubble;
  logic         loadEntry;
  ifIdPayload_t payloadIn;
  ifIdPayload_t payloadOut;

  // Fault check, bubble decision and the word presented to IF/ID.
  always_comb begin
    fault = fetchFault(pcQ, RESET_PC, IM_AW);
    // Bubble on flush; otherwise only on a non-stalled edge, while halted or
    // when a redirect squashes the word in the shadow of the branch.
    bubble = flush | (~stall & ((stateQ == StHalt) | (redirect_valid & (DELAY_SLOT == 0))));
    loadEntry = ~stall & ~bubble;
    payloadIn.instr = fault ? NOP : imem.im_data;
    payloadIn.pc    = pcQ;
    payloadIn.fault = fault;
  end

  // PC, state and counter. Stall freezes all three; redirect beats sequential.
  // A redirect that coincides with a faulting delay-slot load returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcQ    <= RESET_PC;
      stateQ <= StRun;
      countQ <= 32'd0;
    end else if (!stall) begin
      if (redirect_valid) begin
        pcQ    <= redirect_target;
        stateQ <= StRun;
      end else if (stateQ == StRun) begin
        pcQ <= pcQ + 32'd4;
        if (loadEntry && fault) begin
          stateQ <= StHalt;
        end
      end
      if (loadEntry && !fault) begin
        countQ <= countQ + 32'd1;
      end
    end
  end

  if_id_reg #(
    .Width($bits(ifIdPayload_t))
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .bubble  (bubble),
    .validIn (1'b1),
    .dataIn  (payloadIn),
    .validOut(id_valid),
    .dataOut (payloadOut)
  );

  // Combinational outputs derived from the PC and the IF/ID contents.
  always_comb begin
    imem.im_addr = pcQ - RESET_PC;
    pc_out       = pcQ;
    id_instr     = payloadOut.instr;
    id_pc        = payloadOut.pc;
    id_fault     = payloadOut.fault;
    id_pc8       = payloadOut.pc + 32'd8;
    fetch_count  = countQ;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (delay slot on / off) share the control
// stimulus; each has its own memory view. A behavioural model tracks both.
module tb_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirValid;
  logic [31:0] redirTarget;

  logic [31:0] mem [WORDS];

  logic [31:0] pcOut  [2];
  logic [31:0] imAddr [2];
  logic        idValid[2];
  logic [31:0] idInstr[2];
  logic [31:0] idPc   [2];
  logic [31:0] idPc8  [2];
  logic        idFault[2];
  logic [31:0] fetchCount[2];

  int checks = 0;
  int errors = 0;

  // Model state per instance (index 0: delay slot kept, 1: squashed).
  logic [31:0] mPc[2], mI[2], mP[2], mCnt[2];
  bit          mHalt[2], mV[2], mF[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_unit_if imem ();
    assign imem.im_data = mem[imem.im_addr[11:2]];
    assign imAddr[g]    = imem.im_addr;

    fetch_unit #(
      .RESET_PC  (BASE),
      .IM_AW     (10),
      .DELAY_SLOT((g == 0) ? 1 : 0)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirValid),
      .redirect_target(redirTarget),
      .imem           (imem),
      .pc_out         (pcOut[g]),
      .id_valid       (idValid[g]),
      .id_instr       (idInstr[g]),
      .id_pc          (idPc[g]),
      .id_pc8         (idPc8[g]),
      .id_fault       (idFault[g]),
      .fetch_count    (fetchCount[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isFault(input logic [31:0] pc);
    longint p;
    p = longint'(pc);
    return (pc[1:0] != 2'b00) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * WORDS);
  endfunction

  task automatic setIn(input bit r, input bit s, input bit f, input bit rv,
                       input logic [31:0] rt);
    reset = r; stall = s; flush = f; redirValid = rv; redirTarget = rt;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUTs,
  // then compare every observable output against the model.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      bit flt, bub, ld, ds;
      ds = (k == 0);
      if (reset) begin
        mPc[k] = BASE; mHalt[k] = 0; mV[k] = 0; mI[k] = 0; mP[k] = 0; mF[k] = 0;
        mCnt[k] = 0;
      end else begin
        flt = isFault(mPc[k]);
        bub = flush || (!stall && (mHalt[k] || (redirValid && !ds)));
        ld  = !stall && !bub;
        if (bub) begin
          mV[k] = 0; mI[k] = 0; mF[k] = 0;
        end else if (ld) begin
          mV[k] = 1;
          mI[k] = flt ? 32'h0 : mem[(mPc[k] - BASE) >> 2];
          mP[k] = mPc[k];
          mF[k] = flt;
          if (!flt) mCnt[k] = mCnt[k] + 1;
        end
        if (!stall) begin
          if (redirValid) begin
            mPc[k] = redirTarget; mHalt[k] = 0;
          end else if (!mHalt[k]) begin
            if (ld && flt) mHalt[k] = 1;
            mPc[k] = mPc[k] + 4;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.pc_out", k), pcOut[k], mPc[k]);
      chk($sformatf("d%0d.im_addr", k), imAddr[k], mPc[k] - BASE);
      chk($sformatf("d%0d.id_valid", k), 32'(idValid[k]), 32'(mV[k]));
      chk($sformatf("d%0d.id_fault", k), 32'(idFault[k]), 32'(mF[k]));
      chk($sformatf("d%0d.fetch_count", k), fetchCount[k], mCnt[k]);
      if (mV[k]) begin
        chk($sformatf("d%0d.id_instr", k), idInstr[k], mI[k]);
        chk($sformatf("d%0d.id_pc", k), idPc[k], mP[k]);
        chk($sformatf("d%0d.id_pc8", k), idPc8[k], mP[k] + 32'd8);
      end
    end
  endtask

  function automatic logic [31:0] randTarget();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
    else if (r == 7) return BASE + 32'(4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3));
    else if (r == 8) return BASE - 32'(4 * $urandom_range(1, 16));
    else             return BASE + 32'(4 * WORDS + 4 * $urandom_range(0, 16));
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;

    // Reset: everything cleared, PC at the region base.
    setIn(1, 0, 0, 0, 32'h0);
    @(negedge clk);
    step(); step();
    for (int k = 0; k < 2; k++) begin
      chk("rst.pc_out", pcOut[k], 32'h3000);
      chk("rst.id_valid", 32'(idValid[k]), 32'h0);
      chk("rst.id_instr", idInstr[k], 32'h0);
      chk("rst.id_pc", idPc[k], 32'h0);
      chk("rst.id_fault", 32'(idFault[k]), 32'h0);
      chk("rst.fetch_count", fetchCount[k], 32'h0);
    end

    // Free run over A0..A3.
    setIn(0, 0, 0, 0, 32'h0);
    step();
    chk("free.first_id_pc", idPc[0], 32'h3000);
    chk("free.first_instr", idInstr[0], mem[0]);
    repeat (3) step();
    chk("free.id_pc", idPc[0], 32'h300C);
    chk("free.id_instr", idInstr[0], mem[3]);
    chk("free.fetch_count", fetchCount[0], 32'd4);

    // Stall three cycles at pc 0x3008.
    setIn(1, 0, 0, 0, 32'h0); step();
    setIn(0, 0, 0, 0, 32'h0); step(); step();
    setIn(0, 1, 0, 1, 32'h3100);  // redirect during stall is ignored
    repeat (3) step();
    chk("stall.pc_out", pcOut[0], 32'h3008);
    chk("stall.id_pc", idPc[0], 32'h3004);
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("stall.resume_id_pc", idPc[0], 32'h3008);

    // Redirect to 0x3040 while fetching 0x3004.
    setIn(1, 0, 0, 0, 32'h0); step();
    setIn(0, 0, 0, 0, 32'h0); step();
    setIn(0, 0, 0, 1, 32'h3040); step();
    chk("redir.ds_id_pc", idPc[0], 32'h3004);
    chk("redir.ds_valid", 32'(idValid[0]), 32'h1);
    chk("redir.nods_valid", 32'(idValid[1]), 32'h0);
    chk("redir.pc_out", pcOut[1], 32'h3040);
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("redir.tgt_id_pc", idPc[1], 32'h3040);
    chk("redir.tgt_pc8", idPc8[0], 32'h3048);

    // Misaligned fault, HALT, recovery.
    setIn(0, 0, 0, 1, 32'h3002); step();
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("fault.id_fault", 32'(idFault[0]), 32'h1);
    chk("fault.id_instr", idInstr[1], 32'h0);
    chk("fault.id_valid", 32'(idValid[1]), 32'h1);
    step(); step();
    chk("halt.bubble", 32'(idValid[0]), 32'h0);
    chk("halt.count", fetchCount[1], mCnt[1]);
    setIn(0, 0, 0, 1, 32'h3000); step();
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("recover.id_pc", idPc[0], 32'h3000);
    chk("recover.id_fault", 32'(idFault[0]), 32'h0);

    // Last word of the region, then sequential step into the top bound.
    setIn(0, 0, 0, 1, 32'h3FFC); step();
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("top.last_fault", 32'(idFault[1]), 32'h0);
    step();
    chk("top.over_fault", 32'(idFault[1]), 32'h1);
    chk("top.over_pc", idPc[1], 32'h4000);

    // Out-of-range redirect, then reset during HALT (with stall held).
    setIn(0, 0, 0, 1, 32'h4000); step();
    setIn(0, 0, 0, 0, 32'h0); step();
    chk("oor.fault", 32'(idFault[0]), 32'h1);
    step();
    setIn(1, 1, 0, 0, 32'h0); step();
    chk("oor.rst_pc", pcOut[0], 32'h3000);
    chk("oor.rst_valid", 32'(idValid[0]), 32'h0);
    chk("oor.rst_count", fetchCount[1], 32'h0);

    // Random traffic against the model.
    setIn(0, 0, 0, 0, 32'h0); step();
    for (int n = 0; n < 600; n++) begin
      setIn($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, randTarget());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It is the initiator side of the instruction-memory read port. It owns the PC, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It also handles stall, flush, branch/jump redirect with an optional delay slot, and fetch-fault detection.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value after reset; base of the instruction region.
- `IM_AW`, default 10: instruction-memory word-address width; the region covers 4·2^IM_AW bytes.
- `DELAY_SLOT`, default 1: 1 means the word fetched in the redirect cycle is kept (MIPS delay slot); 0 means it is squashed.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the PC and IF/ID contents.
- `flush` in 1: load a bubble into IF/ID.
- `redirect_valid` in 1: take `redirect_target` as the next PC.
- `redirect_target` in 32: branch/jump destination.
- `im_addr` out 32: byte offset `pc - RESET_PC`; the memory indexes bits [IM_AW+1:2].
- `im_data` in 32: instruction word, valid in the same cycle (combinational memory).
- `pc_out` out 32: current fetch PC.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_instr` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID PC.
- `id_pc8` out 32: `id_pc + 8`, the link address.
- `id_fault` out 1: the IF/ID entry came from a faulting fetch.
- `fetch_count` out 32: number of IF/ID loads with a valid, non-faulting instruction.

## Operation
- **Fault condition:** a fetch faults when `pc[1:0] != 0`, or when `pc < RESET_PC`, or when `pc >= RESET_PC + 4·2^IM_AW`.
  - A faulting fetch loads IF/ID with `id_instr = 0` (nop), `id_valid = 1`, `id_fault = 1`.
  - `im_data` is ignored for a faulting fetch.
- **Two states:**
  - RUN: the normal fetch state.
  - HALT: entered on the edge that loads a faulting fetch into IF/ID. In HALT, the PC holds, and IF/ID loads bubbles whenever it is not stalled. HALT returns to RUN only on a redirect or on reset.
- **Per-edge priority:** reset > stall > redirect > sequential.
  - **Reset:** `pc = RESET_PC`. IF/ID is cleared: `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `id_fault = 0`. `fetch_count = 0`. State goes to RUN.
  - **Stall (without flush):** PC, IF/ID, state and counter all hold. `redirect_valid` is ignored in a stalled cycle; the requester must keep it asserted until a non-stalled cycle.
  - **Flush:** IF/ID loads a bubble even when `stall = 1`. The PC still obeys stall/redirect.
  - **Redirect (not stalled):** `pc <= redirect_target`, and state goes to RUN.
    - With `DELAY_SLOT = 1`, the word fetched this cycle enters IF/ID normally.
    - With `DELAY_SLOT = 0`, IF/ID loads a bubble.
  - **Sequential (RUN, no stall, no redirect):** `pc <= pc + 4` with 32-bit wrap. IF/ID loads `{1, im_data, pc, fault}`.
- **Counter:** `fetch_count` increments on each IF/ID load with `id_valid = 1` and `id_fault = 0`. It wraps at 2^32.
- **Arithmetic:** `id_pc8 = id_pc + 8`, combinational, 32-bit modulo.

## Timing
- `im_addr` and `pc_out` are combinational from the PC register. Fetch-to-IF/ID latency is 1 edge.
- Reset released before edge N: edge N loads IF/ID with PC 0x3000, and `pc` becomes 0x3004.
- Redirect asserted in cycle k (not stalled): `pc_out = redirect_target` in cycle k+1. The target appears in `id_pc` after edge k+1.
- Stall for n cycles: the outputs are frozen for exactly n edges. The sequence then resumes with no skipped or duplicated PC.
- Reset asserted mid-stall or mid-HALT: reset wins on that edge.

## Structure
- Shared package/header:
  - `RESET_PC` default.
  - `NOP` constant 32'h0.
  - `IM_AW` default.
  - State encodings RUN/HALT.
- One natural sub-module: `if_id_reg`, the IF/ID pipeline register with load, stall and bubble controls, reused by later stage registers.
- The PC, fault checker and state register live in `fetch_unit`.

## Test plan
- **Reset then free run:** memory words A0..A3 at offsets 0..12, no stall. Required: `id_pc` = 0x3000, 0x3004, 0x3008, 0x300C on consecutive edges; `id_instr` = A0..A3; `fetch_count = 4`.
- **Stall:** assert `stall` for 3 cycles while `pc = 0x3008`. Required: IF/ID and `pc_out` are frozen for 3 edges; the next load has `id_pc = 0x3008`.
- **Redirect with delay slot:** `DELAY_SLOT = 1`, redirect to 0x3040 while fetching 0x3004. Required: IF/ID gets 0x3004 on that edge, then 0x3040 on the next; `id_pc8 = 0x3048`.
- **Redirect without delay slot:** `DELAY_SLOT = 0`, same stimulus. Required: a bubble (`id_valid = 0`), then 0x3040.
- **Fault and recovery:** redirect to 0x3002. Required: IF/ID gets `id_fault = 1`, `id_instr = 0`; bubbles follow and the PC holds. A redirect to 0x3000 then resumes normal fetch, and `fetch_count` excludes the faulting entry.
- **Out-of-range fetch, then reset:** redirect to 0x4000 with `IM_AW = 10`. Required: a fault follows. Then assert `reset` during HALT: `pc = 0x3000` and all outputs are cleared after that edge.
